// File: rtl/rename_regfile_pkg.sv
// Shared widths, tag/data encodings and table types for the rename register file.
package rename_regfile_pkg;

    localparam int NREG    = 32;
    localparam int NBRANCH = 4;
    localparam int REG_AW  = 5;
    localparam int BR_AW   = 2;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 5;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [TAG_W-1:0]  tag_t;
    typedef tag_t [NREG-1:0]   tag_table_t;

    // ROB tags are {1'b0, index}; a set MSB means "no producer pending".
    localparam tag_t  TAG_FREE  = 5'h10;
    localparam data_t DATA_FREE = 32'h0;

endpackage

// File: rtl/rename_regfile_tag_ckpt_bank.sv
// Per-branch snapshots of the live tag table, with valid bits and commit-time clearing
// so a later restore never resurrects a tag that has already retired.
module rename_regfile_tag_ckpt_bank
    import rename_regfile_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_snap_en,
    input  logic [BR_AW-1:0] i_snap_num,
    input  tag_table_t       i_snap_table,
    input  logic             i_free_en,
    input  logic [BR_AW-1:0] i_free_num,
    input  logic             i_clr_en,
    input  tag_t             i_clr_tag,
    output tag_table_t       o_slot_table,
    output logic             o_slot_valid
);

    tag_table_t         r_slot [NBRANCH];
    logic [NBRANCH-1:0] r_valid;

    assign o_slot_table = r_slot[i_free_num];
    assign o_slot_valid = r_valid[i_free_num];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            // NOTE: the snapshot array is reset because a freshly invalid slot must read as all-free.
            for (int b = 0; b < NBRANCH; b++) r_slot[b] <= {NREG{TAG_FREE}};
        end else if (i_en) begin
            for (int b = 0; b < NBRANCH; b++) begin
                for (int r = 0; r < NREG; r++) begin
                    if (i_clr_en && r_valid[b] && r_slot[b][r] == i_clr_tag) r_slot[b][r] <= TAG_FREE;
                end
            end
            // NOTE: non-blocking writes let a later snapshot to the same slot override the free/clear above.
            if (i_free_en) r_valid[i_free_num] <= 1'b0;
            if (i_snap_en) begin
                r_slot[i_snap_num]  <= i_snap_table;
                r_valid[i_snap_num] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with rename tags, ROB commit retirement and branch checkpoints.
// Define REGFILE_COMMIT_BYPASS_EN to forward same-cycle commit data onto the read ports.
module rename_regfile
    import rename_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [REG_AW-1:0] ReadAddrO,
    input  logic [REG_AW-1:0] ReadAddrT,
    output data_t             ReadDataO,
    output tag_t              ReadTagO,
    output data_t             ReadDataT,
    output tag_t              ReadTagT,
    input  logic              enRename,
    input  logic [REG_AW-1:0] RenameAddr,
    input  tag_t              RenameTag,
    input  logic              enCom,
    input  tag_t              ComTag,
    input  data_t             ComData,
    input  logic              enCkpt,
    input  logic [BR_AW-1:0]  CkptNum,
    input  logic              bFreeEn,
    input  logic [BR_AW-1:0]  bFreeNum,
    input  logic              misTaken
);

    data_t      r_data [NREG];
    tag_table_t r_tag;

    logic       w_com_hit;
    logic       w_misp;
    tag_table_t w_live_clr;
    tag_table_t w_live_ren;
    tag_table_t w_ckpt_clr;
    tag_table_t w_tag_next;
    tag_table_t w_slot_table;
    logic       w_slot_valid;

    assign w_com_hit = rdy && enCom && (ComTag != TAG_FREE);
    assign w_misp    = bFreeEn && misTaken;

    rename_regfile_tag_ckpt_bank u_ckpt (
        .clk          (clk),
        .rst_n        (rst),
        .i_en         (rdy),
        .i_snap_en    (enCkpt && !w_misp),
        .i_snap_num   (CkptNum),
        .i_snap_table (w_live_ren),
        .i_free_en    (bFreeEn),
        .i_free_num   (bFreeNum),
        .i_clr_en     (w_com_hit),
        .i_clr_tag    (ComTag),
        .o_slot_table (w_slot_table),
        .o_slot_valid (w_slot_valid)
    );

    always_comb begin
        // NOTE: every output of this block gets a full default first so no latch is inferred.
        w_live_clr = r_tag;
        w_ckpt_clr = w_slot_table;
        for (int r = 0; r < NREG; r++) begin
            if (w_com_hit && r_tag[r] == ComTag)        w_live_clr[r] = TAG_FREE;
            if (w_com_hit && w_slot_table[r] == ComTag) w_ckpt_clr[r] = TAG_FREE;
        end
        w_live_ren = w_live_clr;
        if (enRename && RenameAddr != '0) w_live_ren[RenameAddr] = RenameTag;
        w_tag_next = w_live_ren;
        // A squashed dispatcher's rename is dropped; the retiring tag is still cleared.
        if (w_misp) w_tag_next = w_slot_valid ? w_ckpt_clr : w_live_clr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag <= {NREG{TAG_FREE}};
            for (int r = 0; r < NREG; r++) r_data[r] <= DATA_FREE;
        end else if (rdy) begin
            r_tag <= w_tag_next;
            for (int r = 0; r < NREG; r++) begin
                if (w_com_hit && r_tag[r] == ComTag) r_data[r] <= ComData;
            end
        end
    end

    always_comb begin
        ReadDataO = r_data[ReadAddrO];
        ReadTagO  = r_tag[ReadAddrO];
        ReadDataT = r_data[ReadAddrT];
        ReadTagT  = r_tag[ReadAddrT];
`ifdef REGFILE_COMMIT_BYPASS_EN
        if (w_com_hit && r_tag[ReadAddrO] == ComTag) begin
            ReadDataO = ComData;
            ReadTagO  = TAG_FREE;
        end
        if (w_com_hit && r_tag[ReadAddrT] == ComTag) begin
            ReadDataT = ComData;
            ReadTagT  = TAG_FREE;
        end
`endif
        if (ReadAddrO == '0) begin
            ReadDataO = '0;
            ReadTagO  = TAG_FREE;
        end
        if (ReadAddrT == '0) begin
            ReadDataT = '0;
            ReadTagT  = TAG_FREE;
        end
    end

    a_misp_valid_slot: assert property (@(posedge clk) disable iff (!rst)
        (rdy && bFreeEn && misTaken) |-> w_slot_valid)
        else $error("mispredict resolved against an invalid checkpoint slot");

endmodule

// File: tb/tb_rename_regfile.sv
// Directed, table-driven bench for rename_regfile: rename, commit, checkpoint/restore, rdy, async reset.
module tb_rename_regfile;
    import rename_regfile_pkg::*;

    localparam logic [4:0] TF = 5'h10;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [4:0]  ReadAddrO, ReadAddrT, RenameAddr;
    logic [31:0] ReadDataO, ReadDataT, ComData;
    logic [4:0]  ReadTagO, ReadTagT, RenameTag, ComTag;
    logic        enRename, enCom, enCkpt, bFreeEn, misTaken;
    logic [1:0]  CkptNum, bFreeNum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rename_regfile dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ReadAddrO(ReadAddrO), .ReadAddrT(ReadAddrT),
        .ReadDataO(ReadDataO), .ReadTagO(ReadTagO),
        .ReadDataT(ReadDataT), .ReadTagT(ReadTagT),
        .enRename(enRename), .RenameAddr(RenameAddr), .RenameTag(RenameTag),
        .enCom(enCom), .ComTag(ComTag), .ComData(ComData),
        .enCkpt(enCkpt), .CkptNum(CkptNum),
        .bFreeEn(bFreeEn), .bFreeNum(bFreeNum), .misTaken(misTaken)
    );

    typedef struct {
        logic        rdy;
        logic        ren;  logic [4:0] ra;  logic [4:0] rt;
        logic        com;  logic [4:0] ct;  logic [31:0] cd;
        logic        ck;   logic [1:0] cn;
        logic        bf;   logic [1:0] bn;  logic mis;
        logic [4:0]  ao;   logic [4:0] at;
        logic [31:0] edo;  logic [4:0] eto;
        logic [31:0] edt;  logic [4:0] ett;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rdy = 1'b1; enRename = 1'b0; enCom = 1'b0; enCkpt = 1'b0; bFreeEn = 1'b0; misTaken = 1'b0;
        RenameAddr = '0; RenameTag = '0; ComTag = '0; ComData = '0; CkptNum = '0; bFreeNum = '0;
    endtask

    task automatic add(input logic rd, input logic ren, input int ra, input int rt,
                       input logic com, input int ct, input int cd,
                       input logic ck, input int cn, input logic bf, input int bn, input logic mis,
                       input int ao, input int at, input int edo, input int eto, input int edt, input int ett);
        vec_t v;
        v.rdy = rd; v.ren = ren; v.ra = 5'(ra); v.rt = 5'(rt);
        v.com = com; v.ct = 5'(ct); v.cd = 32'(cd);
        v.ck = ck; v.cn = 2'(cn); v.bf = bf; v.bn = 2'(bn); v.mis = mis;
        v.ao = 5'(ao); v.at = 5'(at);
        v.edo = 32'(edo); v.eto = 5'(eto); v.edt = 32'(edt); v.ett = 5'(ett);
        vecs.push_back(v);
    endtask

    initial begin
        idle();
        rst = 1'b0; ReadAddrO = 5'd5; ReadAddrT = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1; #1;
        check("reset_x5_data", ReadDataO, 32'h0);
        check("reset_x5_tag",  32'(ReadTagO), 32'(TF));
        check("reset_x0_data", ReadDataT, 32'h0);
        check("reset_x0_tag",  32'(ReadTagT), 32'(TF));

        //  rdy ren ra rt  com ct cd      ck cn bf bn mis  ao at  edo     eto  edt     ett
        add(1, 1, 0, 3,  0, 0, 0,       0, 0, 0, 0, 0,   0, 5,  0,      TF,  0,      TF); // rename x0 ignored
        add(1, 1, 5, 2,  0, 0, 0,       0, 0, 0, 0, 0,   5, 0,  0,      2,   0,      TF);
        add(1, 0, 0, 0,  1, 2, 'h1234,  0, 0, 0, 0, 0,   5, 7,  'h1234, TF,  0,      TF);
        add(1, 1, 7, 1,  0, 0, 0,       0, 0, 0, 0, 0,   7, 5,  0,      1,   'h1234, TF);
        add(1, 1, 7, 4,  1, 1, 'hAB,    0, 0, 0, 0, 0,   7, 5,  'hAB,   4,   'h1234, TF); // rename wins
        add(1, 1, 3, 1,  0, 0, 0,       0, 0, 0, 0, 0,   3, 7,  0,      1,   'hAB,   4);
        add(1, 0, 0, 0,  0, 0, 0,       1, 2, 0, 0, 0,   3, 7,  0,      1,   'hAB,   4);
        add(1, 1, 3, 5,  0, 0, 0,       0, 0, 0, 0, 0,   3, 7,  0,      5,   'hAB,   4);
        add(1, 0, 0, 0,  0, 0, 0,       0, 0, 1, 2, 1,   3, 7,  0,      1,   'hAB,   4); // restore slot 2
        add(1, 0, 0, 0,  0, 0, 0,       1, 1, 0, 0, 0,   3, 7,  0,      1,   'hAB,   4);
        add(1, 1, 3, 6,  0, 0, 0,       0, 0, 0, 0, 0,   3, 7,  0,      6,   'hAB,   4);
        add(1, 1, 8, 7,  1, 1, 'h77,    0, 0, 1, 1, 1,   3, 8,  0,      TF,  0,      TF); // restore + clear
        add(1, 1, 4, 6,  0, 0, 0,       1, 0, 0, 0, 0,   4, 3,  0,      6,   0,      TF);
        add(1, 0, 0, 0,  1, 6, 'h66,    0, 0, 0, 0, 0,   4, 3,  'h66,   TF,  0,      TF);
        add(1, 1, 4, 7,  0, 0, 0,       0, 0, 0, 0, 0,   4, 7,  'h66,   7,   'hAB,   4);
        add(1, 0, 0, 0,  0, 0, 0,       0, 0, 1, 0, 1,   4, 7,  'h66,   TF,  'hAB,   4); // ckpt was cleared
        add(1, 0, 0, 0,  0, 0, 0,       1, 3, 0, 0, 0,   7, 4,  'hAB,   4,   'h66,   TF);
        add(1, 1, 7, 8,  0, 0, 0,       0, 0, 1, 3, 0,   7, 4,  'hAB,   8,   'h66,   TF); // correct resolve
        add(0, 1,10, 2,  1, 8, 1,       0, 0, 0, 0, 0,  10, 7,  0,      TF,  'hAB,   8);  // rdy low holds
        add(1, 1, 1, 3,  0, 0, 0,       1, 2, 0, 0, 0,   1, 7,  0,      3,   'hAB,   8);  // ckpt sees rename
        add(1, 1, 1, 9,  0, 0, 0,       0, 0, 0, 0, 0,   1, 7,  0,      9,   'hAB,   8);
        add(1, 0, 0, 0,  0, 0, 0,       0, 0, 1, 2, 1,   1, 7,  0,      3,   'hAB,   8);

        foreach (vecs[i]) begin
            @(negedge clk);
            rdy = vecs[i].rdy;
            enRename = vecs[i].ren; RenameAddr = vecs[i].ra; RenameTag = vecs[i].rt;
            enCom = vecs[i].com; ComTag = vecs[i].ct; ComData = vecs[i].cd;
            enCkpt = vecs[i].ck; CkptNum = vecs[i].cn;
            bFreeEn = vecs[i].bf; bFreeNum = vecs[i].bn; misTaken = vecs[i].mis;
            @(posedge clk); #1;
            idle();
            ReadAddrO = vecs[i].ao; ReadAddrT = vecs[i].at; #1;
            check($sformatf("v%0d_data_o", i), ReadDataO, vecs[i].edo);
            check($sformatf("v%0d_tag_o", i),  32'(ReadTagO), 32'(vecs[i].eto));
            check($sformatf("v%0d_data_t", i), ReadDataT, vecs[i].edt);
            check($sformatf("v%0d_tag_t", i),  32'(ReadTagT), 32'(vecs[i].ett));
        end

        // Same-cycle commit visibility on the read port.
        @(negedge clk); enRename = 1'b1; RenameAddr = 5'd9; RenameTag = 5'd12;
        @(posedge clk); #1; idle();
        @(negedge clk); enCom = 1'b1; ComTag = 5'd12; ComData = 32'h55; ReadAddrO = 5'd9; #1;
`ifdef REGFILE_COMMIT_BYPASS_EN
        check("bypass_data", ReadDataO, 32'h55);
        check("bypass_tag",  32'(ReadTagO), 32'(TF));
`else
        check("nobypass_data", ReadDataO, 32'h0);
        check("nobypass_tag",  32'(ReadTagO), 32'd12);
`endif
        @(posedge clk); #1; idle(); #1;
        check("commit_x9_data", ReadDataO, 32'h55);
        check("commit_x9_tag",  32'(ReadTagO), 32'(TF));

        // Asynchronous reset between clock edges.
        @(negedge clk); ReadAddrO = 5'd7; ReadAddrT = 5'd5; #1;
        rst = 1'b0; #1;
        check("async_rst_x7_tag",  32'(ReadTagO), 32'(TF));
        check("async_rst_x7_data", ReadDataO, 32'h0);
        check("async_rst_x5_data", ReadDataT, 32'h0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
